kernel_multi_channel_counter: RTL and testbench

//  - C_CHANNELS independent up/down counters of C_WIDTH bits behind one clock enable.
//  - Per-channel load, registered zero/max flags, and overflow/underflow pulses.
//  - Wrap or saturate mode is chosen at elaboration.
//  - Used in kernel control paths: beat/burst/outstanding-transaction counting per AXI channel.

---
 rtl/kernel_multi_channel_counter.sv | 104 ++++++++++
 tb/tb_kernel_multi_channel_counter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/kernel_multi_channel_counter.sv
// Per-channel up/down counters with load, registered zero/max flags and overflow/underflow pulses.
// Optional build macro COUNTER_STEP_EN adds a per-channel step input; default step is 1.
module kernel_multi_channel_counter #(
  parameter int                 C_WIDTH    = 4,
  parameter int                 C_CHANNELS = 2,
  parameter int                 C_SATURATE = 0,
  parameter logic [C_WIDTH-1:0] C_INIT     = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clken_i,
  input  logic [C_CHANNELS-1:0]           load_i,
  input  logic [C_CHANNELS-1:0]           incr_i,
  input  logic [C_CHANNELS-1:0]           decr_i,
  input  logic [C_CHANNELS*C_WIDTH-1:0]   load_value_i,
`ifdef COUNTER_STEP_EN
  input  logic [C_CHANNELS*C_WIDTH-1:0]   step_i,
`endif
  output logic [C_CHANNELS*C_WIDTH-1:0]   count_o,
  output logic [C_CHANNELS-1:0]           is_zero_o,
  output logic [C_CHANNELS-1:0]           is_max_o,
  output logic [C_CHANNELS-1:0]           ovf_o,
  output logic [C_CHANNELS-1:0]           unf_o
);

  localparam logic [C_WIDTH-1:0] MAX      = '1;
  localparam bit                 SAT      = (C_SATURATE != 0);
  localparam bit                 INIT_ZER = (C_INIT == '0);
  localparam bit                 INIT_MAX = (C_INIT == MAX);

  logic [C_CHANNELS*C_WIDTH-1:0] count_q, count_d;
  logic [C_CHANNELS-1:0]         is_zero_q, is_zero_d;
  logic [C_CHANNELS-1:0]         is_max_q, is_max_d;
  logic [C_CHANNELS-1:0]         ovf_q, ovf_d;
  logic [C_CHANNELS-1:0]         unf_q, unf_d;

  for (genvar i = 0; i < C_CHANNELS; i++) begin : g_ch
    logic [C_WIDTH-1:0] cur;
    logic [C_WIDTH-1:0] stp;
    logic [C_WIDTH:0]   sum;
    logic [C_WIDTH:0]   diff;
    logic [C_WIDTH-1:0] nxt;
    logic               ovf_n;
    logic               unf_n;

    assign cur = count_q[i*C_WIDTH +: C_WIDTH];
`ifdef COUNTER_STEP_EN
    assign stp = step_i[i*C_WIDTH +: C_WIDTH];
`else
    assign stp = C_WIDTH'(1);
`endif
    // Bit C_WIDTH of sum is the carry, of diff the borrow.
    assign sum  = {1'b0, cur} + {1'b0, stp};
    assign diff = {1'b0, cur} - {1'b0, stp};

    always_comb begin
      nxt   = cur;
      ovf_n = 1'b0;
      unf_n = 1'b0;
      if (load_i[i]) begin
        nxt = load_value_i[i*C_WIDTH +: C_WIDTH];
      end else if (incr_i[i] && !decr_i[i]) begin
        ovf_n = sum[C_WIDTH];
        nxt   = (SAT && sum[C_WIDTH]) ? MAX : sum[C_WIDTH-1:0];
      end else if (decr_i[i] && !incr_i[i]) begin
        unf_n = diff[C_WIDTH];
        nxt   = (SAT && diff[C_WIDTH]) ? '0 : diff[C_WIDTH-1:0];
      end
    end

    assign count_d[i*C_WIDTH +: C_WIDTH] = nxt;
    assign is_zero_d[i] = (nxt == '0);
    assign is_max_d[i]  = (nxt == MAX);
    assign ovf_d[i]     = ovf_n;
    assign unf_d[i]     = unf_n;
  end

  // Flags are computed from the next count so they never lag the count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= {C_CHANNELS{C_INIT}};
      is_zero_q <= {C_CHANNELS{INIT_ZER}};
      is_max_q  <= {C_CHANNELS{INIT_MAX}};
      ovf_q     <= '0;
      unf_q     <= '0;
    end else if (clken_i) begin
      count_q   <= count_d;
      is_zero_q <= is_zero_d;
      is_max_q  <= is_max_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end else begin
      ovf_q     <= '0;
      unf_q     <= '0;
    end
  end

  assign count_o   = count_q;
  assign is_zero_o = is_zero_q;
  assign is_max_o  = is_max_q;
  assign ovf_o     = ovf_q;
  assign unf_o     = unf_q;

endmodule

// File: tb/tb_kernel_multi_channel_counter.sv
// Directed bench: a wrap-mode and a saturate-mode instance share one stimulus stream.
module tb_kernel_multi_channel_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clken;
  logic [1:0] load, incr, decr;
  logic [7:0] load_value;
`ifdef COUNTER_STEP_EN
  logic [7:0] step;
`endif
  logic [7:0] w_count, s_count;
  logic [1:0] w_zero, w_max, w_ovf, w_unf;
  logic [1:0] s_zero, s_max, s_ovf, s_unf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kernel_multi_channel_counter #(.C_WIDTH(4), .C_CHANNELS(2), .C_SATURATE(0), .C_INIT(4'd0)) u_wrap (
    .clk(clk), .rst(rst), .clken_i(clken), .load_i(load), .incr_i(incr), .decr_i(decr),
    .load_value_i(load_value),
`ifdef COUNTER_STEP_EN
    .step_i(step),
`endif
    .count_o(w_count), .is_zero_o(w_zero), .is_max_o(w_max), .ovf_o(w_ovf), .unf_o(w_unf)
  );

  kernel_multi_channel_counter #(.C_WIDTH(4), .C_CHANNELS(2), .C_SATURATE(1), .C_INIT(4'd0)) u_sat (
    .clk(clk), .rst(rst), .clken_i(clken), .load_i(load), .incr_i(incr), .decr_i(decr),
    .load_value_i(load_value),
`ifdef COUNTER_STEP_EN
    .step_i(step),
`endif
    .count_o(s_count), .is_zero_o(s_zero), .is_max_o(s_max), .ovf_o(s_ovf), .unf_o(s_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [7:0] c, input logic [1:0] z,
                       input logic [1:0] m, input logic [1:0] o, input logic [1:0] u);
    chk({tag, ".w.count"}, w_count, c);
    chk({tag, ".w.zero"}, {6'd0, w_zero}, {6'd0, z});
    chk({tag, ".w.max"},  {6'd0, w_max},  {6'd0, m});
    chk({tag, ".w.ovf"},  {6'd0, w_ovf},  {6'd0, o});
    chk({tag, ".w.unf"},  {6'd0, w_unf},  {6'd0, u});
  endtask

  task automatic chk_s(input string tag, input logic [7:0] c, input logic [1:0] z,
                       input logic [1:0] m, input logic [1:0] o, input logic [1:0] u);
    chk({tag, ".s.count"}, s_count, c);
    chk({tag, ".s.zero"}, {6'd0, s_zero}, {6'd0, z});
    chk({tag, ".s.max"},  {6'd0, s_max},  {6'd0, m});
    chk({tag, ".s.ovf"},  {6'd0, s_ovf},  {6'd0, o});
    chk({tag, ".s.unf"},  {6'd0, s_unf},  {6'd0, u});
  endtask

  initial begin
    rst = 1'b1; clken = 1'b1; load = 2'b00; incr = 2'b00; decr = 2'b00; load_value = 8'h00;
`ifdef COUNTER_STEP_EN
    step = 8'h11;
`endif
    #1;
    tick(); tick();
    chk_w("reset", 8'h00, 2'b11, 2'b00, 2'b00, 2'b00);
    chk_s("reset", 8'h00, 2'b11, 2'b00, 2'b00, 2'b00);

    // ch0: load 14 then increment three times through MAX
    rst = 1'b0; load = 2'b01; load_value = 8'h0E;
    tick();
    chk_w("ld14", 8'h0E, 2'b10, 2'b00, 2'b00, 2'b00);
    chk_s("ld14", 8'h0E, 2'b10, 2'b00, 2'b00, 2'b00);
    load = 2'b00; incr = 2'b01;
    tick();
    chk_w("inc1", 8'h0F, 2'b10, 2'b01, 2'b00, 2'b00);
    chk_s("inc1", 8'h0F, 2'b10, 2'b01, 2'b00, 2'b00);
    tick();
    chk_w("inc2", 8'h00, 2'b11, 2'b00, 2'b01, 2'b00);
    chk_s("inc2", 8'h0F, 2'b10, 2'b01, 2'b01, 2'b00);
    tick();
    chk_w("inc3", 8'h01, 2'b10, 2'b00, 2'b00, 2'b00);
    chk_s("inc3", 8'h0F, 2'b10, 2'b01, 2'b01, 2'b00);

    // ch1: load 1 then decrement three times through zero
    incr = 2'b00; load = 2'b10; load_value = 8'h10;
    tick();
    chk_w("ld1", 8'h11, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_s("ld1", 8'h1F, 2'b00, 2'b01, 2'b00, 2'b00);
    load = 2'b00; decr = 2'b10;
    tick();
    chk_w("dec1", 8'h01, 2'b10, 2'b00, 2'b00, 2'b00);
    chk_s("dec1", 8'h0F, 2'b10, 2'b01, 2'b00, 2'b00);
    tick();
    chk_w("dec2", 8'hF1, 2'b00, 2'b10, 2'b00, 2'b10);
    chk_s("dec2", 8'h0F, 2'b10, 2'b01, 2'b00, 2'b10);
    tick();
    chk_w("dec3", 8'hE1, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_s("dec3", 8'h0F, 2'b10, 2'b01, 2'b00, 2'b10);

    // Simultaneous: ch0 load wins over incr; ch1 incr&decr holds
    decr = 2'b00; load = 2'b10; load_value = 8'h30;
    tick();
    chk_w("ld3", 8'h31, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_s("ld3", 8'h3F, 2'b00, 2'b01, 2'b00, 2'b00);
    load = 2'b01; load_value = 8'h75; incr = 2'b11; decr = 2'b10;
    tick();
    chk_w("simul", 8'h35, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_s("simul", 8'h35, 2'b00, 2'b00, 2'b00, 2'b00);

    // Clock enable low freezes everything
    load = 2'b00; decr = 2'b00; incr = 2'b11; clken = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk_w("clken0", 8'h35, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_s("clken0", 8'h35, 2'b00, 2'b00, 2'b00, 2'b00);
    clken = 1'b1;
    tick();
    chk_w("clken1", 8'h46, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_s("clken1", 8'h46, 2'b00, 2'b00, 2'b00, 2'b00);

    // Reset while an overflowing increment is requested
    incr = 2'b00; load = 2'b01; load_value = 8'h0F;
    tick();
    chk_w("ld15", 8'h4F, 2'b00, 2'b01, 2'b00, 2'b00);
    load = 2'b00; incr = 2'b01; rst = 1'b1;
    tick();
    chk_w("rstmid", 8'h00, 2'b11, 2'b00, 2'b00, 2'b00);
    chk_s("rstmid", 8'h00, 2'b11, 2'b00, 2'b00, 2'b00);
    rst = 1'b0; incr = 2'b00;

`ifdef COUNTER_STEP_EN
    load = 2'b01; load_value = 8'h0C;
    tick();
    chk_w("ld12", 8'h0C, 2'b10, 2'b00, 2'b00, 2'b00);
    load = 2'b00; step = 8'h16; incr = 2'b01;
    tick();
    chk_w("step6", 8'h02, 2'b10, 2'b00, 2'b01, 2'b00);
    chk_s("step6", 8'h0F, 2'b10, 2'b01, 2'b01, 2'b00);
    incr = 2'b00; step = 8'h10; decr = 2'b01;
    tick();
    chk_w("step0", 8'h02, 2'b10, 2'b00, 2'b00, 2'b00);
    chk_s("step0", 8'h0F, 2'b10, 2'b01, 2'b00, 2'b00);
    decr = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
